// File: rtl/mux_pkg.sv
// mux_pkg
// Shared constants for the stream multiplexer family: the selection-mode
// encoding used on the mode input and the default channel geometry.
// No ports; import with "import mux_pkg::*;".
package mux_pkg;

    // Encoding of the mode input
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Default geometry: 4 channels of 2-bit words
    localparam int DEFAULT_WIDTH = 2;
    localparam int DEFAULT_N_CH  = 4;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Fair round-robin arbiter over N_CH requesters. The search for a winner
// starts just after the last channel that was served and wraps past
// N_CH-1 back to 0. The pointer moves only when the owner pulses advance,
// so a grant that is not taken leaves the rotation where it was.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (pointer -> N_CH-1)
//   req          per-channel request vector
//   advance      strobe: the current grant was consumed this cycle
//   grant        index of the winning channel (valid when grant_valid)
//   grant_valid  at least one channel is requesting
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N_CH  = DEFAULT_N_CH,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             advance,
    output logic [SEL_W-1:0] grant,
    output logic             grant_valid
);

    logic [SEL_W-1:0] last;
    int               idx;

    // Rotating priority search. Offsets 1..N_CH from the last winner are
    // visited in order, so the last winner itself is checked last. The
    // wrap is done by subtraction because N_CH need not be a power of two.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = int'(last) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!grant_valid && req[idx]) begin
                grant       = SEL_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    // Pointer register. Resetting to N_CH-1 makes channel 0 the first
    // candidate after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= SEL_W'(N_CH - 1);
        end else if (advance && grant_valid) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// N-channel valid/ready stream multiplexer with a single registered output
// stage. Channels are chosen either by an external select (manual mode) or
// by a round-robin arbiter (RR mode). Every output word carries the index
// of the channel it came from.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    N_CH*WIDTH packed input words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit high)
//   mode       MODE_MANUAL (0) or MODE_RR (1)
//   select     channel index used in manual mode
//   out_data   registered output word
//   out_valid  registered output valid
//   out_ready  downstream ready
//   out_chan   registered source channel of out_data
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int N_CH  = DEFAULT_N_CH,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      select,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_chan
);

    logic [SEL_W-1:0] rr_grant;
    logic             rr_valid;
    logic             man_valid;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             load;
    logic             transfer;
    logic             advance;
    logic [WIDTH-1:0] sel_data;

    // The arbiter only sees its pointer move on RR-mode transfers, so it
    // stays frozen while manual mode is in use and resumes from there.
    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req         (in_valid),
        .advance     (advance),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    // Manual grant check. Comparing against each legal index (instead of
    // indexing in_valid with select) keeps an out-of-range select from
    // reading past the vector; such a select simply never matches.
    always_comb begin
        man_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (select == SEL_W'(i) && in_valid[i]) begin
                man_valid = 1'b1;
            end
        end
    end

    // Grant selection by mode, and the load enable of the one-entry
    // output register: it can take a word when empty or when the word it
    // holds is leaving this cycle, which gives full throughput.
    always_comb begin
        grant       = (mode == MODE_RR) ? rr_grant : select;
        grant_valid = (mode == MODE_RR) ? rr_valid : man_valid;
        load        = !out_valid || out_ready;
    end

    // Ready decode and data mux. Ready is held low during reset so no
    // producer believes a word was taken while the block is being cleared.
    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
                if (!rst && load && grant_valid) begin
                    in_ready[i] = 1'b1;
                end
            end
        end
        transfer = |in_ready;
        advance  = transfer && (mode == MODE_RR);
    end

    // Output register. A transfer always wins; otherwise a consumed word
    // just clears valid while data and channel tag keep their values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
        end else if (transfer) begin
            out_data  <= sel_data;
            out_chan  <= grant;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr
// Self-checking bench for stream_mux_rr. A 4-channel instance carries most
// scenarios; a 3-channel instance exercises the out-of-range select.
// Expected words are queued as each transfer is driven, the monitor records
// every word the DUT hands downstream, and each scenario compares the two
// queues once its words have drained.
module tb_stream_mux_rr;

    typedef struct packed {
        logic [1:0] chan;
        logic [1:0] data;
    } word_t;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic       mode;
    logic [1:0] select;
    logic [1:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_chan;

    logic [5:0] in_data3;
    logic [2:0] in_valid3;
    logic [2:0] in_ready3;
    logic       mode3;
    logic [1:0] select3;
    logic [1:0] out_data3;
    logic       out_valid3;
    logic       out_ready3;
    logic [1:0] out_chan3;

    int    checks;
    int    errors;
    word_t exp_q[$];
    word_t obs_q[$];
    word_t exp_w;
    word_t obs_w;

    stream_mux_rr #(
        .WIDTH (2),
        .N_CH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .select    (select),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
    );

    stream_mux_rr #(
        .WIDTH (2),
        .N_CH  (3)
    ) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .select    (select3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_chan  (out_chan3)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every word the 4-channel DUT hands downstream, sampled on the
    // falling edge so the registered outputs are stable.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            obs_q.push_back(word_t'({out_chan, out_data}));
        end
    end

    // Golden channel contents: channel i carries the 2-bit value i
    function automatic logic [1:0] golden_data(input int ch);
        case (ch)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b10;
            3:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic applyStimulus(input logic m, input logic [1:0] s,
                                 input logic [3:0] v, input logic r);
        mode      = m;
        select    = s;
        in_valid  = v;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        in_valid3 = 3'b111;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 2'b00 || out_chan !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b data=%b chan=%0d, want 0/00/0",
                     out_valid, out_data, out_chan);
        end
        checks++;
        if (in_ready !== 4'b0000 || in_ready3 !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b/%b, want 0000/000", in_ready, in_ready3);
        end
        checks++;
        if (out_valid3 !== 1'b0 || out_data3 !== 2'b00 || out_chan3 !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs3: got valid=%b data=%b chan=%0d, want 0/00/0",
                     out_valid3, out_data3, out_chan3);
        end
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        in_valid3 = 3'b000;
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_manual_sweep();
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b0, 2'(s), 4'b1111, 1'b1);
            @(negedge clk);
            checks++;
            if (in_ready !== (4'b0001 << s)) begin
                errors++;
                $display("[TB] FAIL manual_ready: select=%0d got %b want %b", s, in_ready, 4'b0001 << s);
            end
            exp_q.push_back(word_t'({2'(s), golden_data(s)}));
            if (s > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_chan !== 2'(s - 1) || out_data !== golden_data(s - 1)) begin
                    errors++;
                    $display("[TB] FAIL manual_out: got valid=%b chan=%0d data=%b want 1/%0d/%b",
                             out_valid, out_chan, out_data, s - 1, golden_data(s - 1));
                end
            end
            tick();
        end
        applyStimulus(1'b0, 2'd0, 4'b0000, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd3 || out_data !== 2'b11) begin
            errors++;
            $display("[TB] FAIL manual_last: got valid=%b chan=%0d data=%b want 1/3/11",
                     out_valid, out_chan, out_data);
        end
        tick();
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL manual_word: missing, want chan=%0d data=%b", exp_w.chan, exp_w.data);
            end else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin
                    errors++;
                    $display("[TB] FAIL manual_word: got chan=%0d data=%b want chan=%0d data=%b",
                             obs_w.chan, obs_w.data, exp_w.chan, exp_w.data);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL manual_extra: %0d unexpected words, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_rr_fairness();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
            @(negedge clk);
            checks++;
            if (in_ready !== (4'b0001 << (k % 4))) begin
                errors++;
                $display("[TB] FAIL rr_ready: cycle %0d got %b want %b", k, in_ready, 4'b0001 << (k % 4));
            end
            exp_q.push_back(word_t'({2'(k % 4), golden_data(k % 4)}));
            tick();
        end
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        @(negedge clk);
        tick();
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL rr_word: missing, want chan=%0d data=%b", exp_w.chan, exp_w.data);
            end else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin
                    errors++;
                    $display("[TB] FAIL rr_word: got chan=%0d data=%b want chan=%0d data=%b",
                             obs_w.chan, obs_w.data, exp_w.chan, exp_w.data);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rr_extra: %0d unexpected words, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_rr_skip_wrap();
        logic [3:0] valids [5];
        int         chans  [5];
        valids = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0100};
        chans  = '{0, 3, 0, 3, 2};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 2'd0, valids[k], 1'b1);
            @(negedge clk);
            checks++;
            if (in_ready !== (4'b0001 << chans[k])) begin
                errors++;
                $display("[TB] FAIL skip_ready: step %0d got %b want %b", k, in_ready, 4'b0001 << chans[k]);
            end
            exp_q.push_back(word_t'({2'(chans[k]), golden_data(chans[k])}));
            tick();
        end
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        @(negedge clk);
        tick();
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL skip_word: missing, want chan=%0d data=%b", exp_w.chan, exp_w.data);
            end else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin
                    errors++;
                    $display("[TB] FAIL skip_word: got chan=%0d data=%b want chan=%0d data=%b",
                             obs_w.chan, obs_w.data, exp_w.chan, exp_w.data);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL skip_extra: %0d unexpected words, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_back_pressure();
        // Capture a word from ch1 (pointer moves to 1)
        applyStimulus(1'b1, 2'd0, 4'b0010, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL bp_capture: got %b want 0010", in_ready);
        end
        exp_q.push_back(word_t'({2'd1, 2'b01}));
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 2'd0, 4'b1111, 1'b0);
            @(negedge clk);
            checks++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 2'b01 || out_chan !== 2'd1) begin
                errors++;
                $display("[TB] FAIL bp_hold: cycle %0d got ready=%b valid=%b data=%b chan=%0d want 0000/1/01/1",
                         k, in_ready, out_valid, out_data, out_chan);
            end
            tick();
        end
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL bp_release: got %b want 0100", in_ready);
        end
        exp_q.push_back(word_t'({2'd2, 2'b10}));
        tick();
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd2) begin
            errors++;
            $display("[TB] FAIL bp_no_gap: got valid=%b chan=%0d want 1/2", out_valid, out_chan);
        end
        tick();
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL bp_word: missing, want chan=%0d data=%b", exp_w.chan, exp_w.data);
            end else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin
                    errors++;
                    $display("[TB] FAIL bp_word: got chan=%0d data=%b want chan=%0d data=%b",
                             obs_w.chan, obs_w.data, exp_w.chan, exp_w.data);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL bp_extra: %0d unexpected words, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_mode_switch();
        // Hold a ch1 word (pointer -> 1), stall, then flip to manual ch3
        applyStimulus(1'b1, 2'd0, 4'b0010, 1'b1);
        @(negedge clk);
        exp_q.push_back(word_t'({2'd1, 2'b01}));
        tick();
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0000 || out_chan !== 2'd1) begin
            errors++;
            $display("[TB] FAIL switch_stall: got ready=%b chan=%0d want 0000/1", in_ready, out_chan);
        end
        tick();
        applyStimulus(1'b0, 2'd3, 4'b1111, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 2'b01 || out_chan !== 2'd1) begin
            errors++;
            $display("[TB] FAIL switch_held: got ready=%b valid=%b data=%b chan=%0d want 0000/1/01/1",
                     in_ready, out_valid, out_data, out_chan);
        end
        tick();
        applyStimulus(1'b0, 2'd3, 4'b1111, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL switch_manual: got %b want 1000", in_ready);
        end
        exp_q.push_back(word_t'({2'd3, 2'b11}));
        tick();
        // Back to RR: frozen pointer (1) means ch2 is next
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL switch_resume: got %b want 0100", in_ready);
        end
        exp_q.push_back(word_t'({2'd2, 2'b10}));
        tick();
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        @(negedge clk);
        tick();
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL switch_word: missing, want chan=%0d data=%b", exp_w.chan, exp_w.data);
            end else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin
                    errors++;
                    $display("[TB] FAIL switch_word: got chan=%0d data=%b want chan=%0d data=%b",
                             obs_w.chan, obs_w.data, exp_w.chan, exp_w.data);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL switch_extra: %0d unexpected words, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_illegal_select();
        for (int k = 0; k < 3; k++) begin
            mode3 = 1'b0; select3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready3 !== 3'b000 || out_valid3 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL illegal_select: cycle %0d got ready=%b valid=%b want 000/0",
                         k, in_ready3, out_valid3);
            end
            tick();
        end
        select3 = 2'd2;
        @(negedge clk);
        checks++;
        if (in_ready3 !== 3'b100) begin
            errors++;
            $display("[TB] FAIL legal_select_ready: got %b want 100", in_ready3);
        end
        tick();
        in_valid3 = 3'b000;
        @(negedge clk);
        checks++;
        if (out_valid3 !== 1'b1 || out_data3 !== 2'b10 || out_chan3 !== 2'd2) begin
            errors++;
            $display("[TB] FAIL legal_select_out: got valid=%b data=%b chan=%0d want 1/10/2",
                     out_valid3, out_data3, out_chan3);
        end
        tick();
    endtask

    task automatic test_async_reset();
        // Pointer is 2 here: ch3 then ch0
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL areset_pre: got %b want 1000", in_ready);
        end
        exp_q.push_back(word_t'({2'd3, 2'b11}));
        tick();
        @(negedge clk);
        exp_q.push_back(word_t'({2'd0, 2'b00}));
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 2'b00 || out_chan !== 2'd0 || in_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL areset_clear: got valid=%b data=%b chan=%0d ready=%b want 0/00/0/0000",
                     out_valid, out_data, out_chan, in_ready);
        end
        // The ch3 word left before reset; the ch0 word is discarded
        exp_w = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL areset_word: missing, want chan=%0d data=%b", exp_w.chan, exp_w.data);
        end else begin
            obs_w = obs_q.pop_front();
            if (obs_w !== exp_w || obs_q.size() != 0) begin
                errors++;
                $display("[TB] FAIL areset_word: got chan=%0d data=%b (+%0d more) want chan=%0d data=%b",
                         obs_w.chan, obs_w.data, obs_q.size(), exp_w.chan, exp_w.data);
            end
        end
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL areset_first: got %b want 0001", in_ready);
        end
        exp_q.push_back(word_t'({2'd0, 2'b00}));
        tick();
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        @(negedge clk);
        tick();
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL areset_post: missing, want chan=%0d data=%b", exp_w.chan, exp_w.data);
            end else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin
                    errors++;
                    $display("[TB] FAIL areset_post: got chan=%0d data=%b want chan=%0d data=%b",
                             obs_w.chan, obs_w.data, exp_w.chan, exp_w.data);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL areset_extra: %0d unexpected words, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    // Scenario sequence
    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        in_data    = {2'b11, 2'b10, 2'b01, 2'b00};
        in_data3   = {2'b10, 2'b01, 2'b00};
        in_valid3  = 3'b000;
        mode3      = 1'b0;
        select3    = 2'd0;
        out_ready3 = 1'b1;
        applyStimulus(1'b0, 2'd0, 4'b0000, 1'b1);
        #1;
        test_reset();
        test_manual_sweep();
        test_rr_fairness();
        test_rr_skip_wrap();
        test_back_pressure();
        test_mode_switch();
        test_illegal_select();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel stream multiplexer with a registered output stage and valid/ready handshakes on every channel.
- Two selection modes:
  - Manual: an external select picks the channel, as in the existing combinational 4:1 mux.
  - Round-robin: a fair arbiter picks among requesting channels.
- Sits between multiple producers and one consumer.
- Tags every output word with the channel it came from.

Parameters:
- WIDTH, 2, data bits per channel.
- N_CH, 4, number of input channels (≥2; need not be a power of two).
- SEL_W, $clog2(N_CH), width of the select and channel-tag fields (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready; combinational.
- mode  input  1  0 = manual select, 1 = round-robin.
- select  input  SEL_W  channel index used in manual mode.
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_chan  output  SEL_W  registered index of the source channel of out_data.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - out_valid=0, out_data=0, out_chan=0.
  - RR pointer last=N_CH-1, so channel 0 has priority first.
  - in_ready is all-zero while rst is high.
- Load enable: load = !out_valid || out_ready. The output register is a single entry that supports full throughput, one word per cycle.
- Grant:
  - Manual mode: grant = select if select < N_CH and in_valid[select]; otherwise no grant.
  - RR mode: first i with in_valid[i], searching last+1, last+2, … modulo N_CH. The search wraps past N_CH-1 to 0.
- in_ready[i] = load && granted && grant==i. At most one bit is high at a time.
- Transfer on channel i: in_valid[i] && in_ready[i] at the clock edge. The next cycle:
  - out_data = in_data[i];
  - out_chan = i;
  - out_valid = 1.
  - Latency is exactly 1 cycle, input to output.
- Output consumed without a new load (out_valid && out_ready, no transfer): out_valid drops to 0. out_data and out_chan hold their values.
- Stall (out_valid && !out_ready):
  - out_data, out_valid and out_chan are held stable;
  - all in_ready are 0;
  - the pointer is unchanged.
- Pointer update:
  - last ← grant only on a transfer, and only in RR mode.
  - In manual mode the pointer is frozen.
  - Switching back to RR resumes from the frozen pointer.
- Mode or select change while the output is stalled: the in-flight word is unaffected and not lost. The new mode or select applies to the next arbitration only.
- No requests: no transfer, the pointer is held, and out_valid falls once the current word has been consumed.
- select ≥ N_CH (non-power-of-two N_CH): treated as idle. No transfer, no X propagation.
- Reset asserted mid-operation: out_valid clears immediately (async) and the pending word is discarded.
- The block never drops, duplicates or reorders words from any single channel.

Decomposition:
- Shared package mux_pkg:
  - mode encoding constants MODE_MANUAL=1'b0 and MODE_RR=1'b1;
  - default WIDTH and N_CH constants.
- Sub-module rr_arbiter(N_CH): contains the request vector, the pointer register, the grant index and grant-valid logic, and an advance strobe. It is reused by later arbitration blocks.
- The top level holds the data mux, the output register and the handshake logic.

Test Plan (WIDTH=2, N_CH=4, in_data ch0..3 = 00,01,10,11):
- Manual sweep:
  - Stimulus: mode=0, all valid, out_ready=1, select driven 0,1,2,3 on successive cycles.
  - Required response: one cycle later, out_data/out_chan = 00/0, 01/1, 10/2, 11/3 with out_valid=1 each cycle. This is the golden-model check against a case statement.
- RR fairness:
  - Stimulus: mode=1, all valid for 8 cycles, out_ready=1.
  - Required response: out_chan sequence 0,1,2,3,0,1,2,3; in_ready is one-hot each cycle.
- RR skip and wrap:
  - Stimulus: in_valid=4'b1001.
  - Required response: out_chan alternates 0,3,0,3. Then with in_valid=4'b0100, out_chan=2 on the next beat.
- Back-pressure:
  - Stimulus: a word is captured from ch1, then out_ready=0 for 3 cycles.
  - Required response: out_data=01 and out_chan=1 are held, in_ready=0000 and the pointer is unchanged. Raising out_ready gives the next grant to ch2 with no gap.
- Mode switch and illegal select:
  - Stimulus A: while stalled, switch mode 1→0 with select=3. Required: the held word is delivered unchanged, then ch3 (11) follows.
  - Stimulus B: N_CH=3 build with select=3. Required: out_valid stays 0.
- Async reset:
  - Stimulus: assert rst mid-cycle while out_valid=1.
  - Required response: out_valid, out_data and out_chan go to 0 before the next clock edge. After release in RR mode with all channels valid, the first output is ch0.
